// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding memory port arbiter between instruction fetch and load/store
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,

  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [3:0]        ls_be_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [31:0]       ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [31:0]       ls_rdata_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,

  output logic              busy_o,
  output logic              err_o
);

  localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = LS owns the port, 0 = IF
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                err_q, err_d;

  logic ls_win;
  logic any_req;
  logic sel_ls;
  logic req;
  logic gnt;
  logic resp;

  // Fixed LS priority, overridden for IF once LS has won MAX_LS_STREAK times in a row
  always_comb begin
    any_req = ls_req_i || if_req_i;
    ls_win  = ls_req_i && !(if_req_i && (streak_q == STREAK_MAX));
  end

  // Transaction FSM: arbitrate in IDLE, hold the locked request in ADDR, wait for the response in RESP
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel_ls  = owner_q;
    req     = 1'b0;
    gnt     = 1'b0;
    resp    = 1'b0;
    case (state_q)
      IDLE: begin
        sel_ls = ls_win;
        if (any_req) begin
          req     = 1'b1;
          owner_d = ls_win;
          if (mem_gnt_i) begin
            gnt     = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        req = 1'b1;
        if (mem_gnt_i) begin
          gnt     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          resp    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset silences every handshake output, including responses to an abandoned transaction
    if (rst_i) begin
      req  = 1'b0;
      gnt  = 1'b0;
      resp = 1'b0;
    end
  end

  // Streak tracks consecutive LS grants taken while IF was waiting; errors latch stray responses
  always_comb begin
    streak_d = streak_q;
    if (gnt) begin
      if (sel_ls && if_req_i) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
      end else begin
        streak_d = '0;
      end
    end
    err_d = err_q | (mem_rvalid_i && (state_q != RESP));
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  // Memory-side request muxing; IF is always a full-word read
  always_comb begin
    mem_req_o   = req;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (req) begin
      if (sel_ls) begin
        mem_we_o    = ls_we_i;
        mem_be_o    = ls_be_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = if_addr_i;
      end
    end
  end

  // Requester-side grant and response routing; rdata is zero whenever rvalid is low
  always_comb begin
    if_gnt_o    = gnt && !sel_ls;
    ls_gnt_o    = gnt && sel_ls;
    if_rvalid_o = resp && !owner_q;
    ls_rvalid_o = resp && owner_q;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
    ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : 32'h0;
    busy_o      = (state_q != IDLE);
    err_o       = err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i = 1'b0;
  logic        ls_we_i = 1'b0;
  logic [3:0]  ls_be_i = '0;
  logic [31:0] ls_addr_i = '0;
  logic [31:0] ls_wdata_i = '0;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o, err_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic pend_if = 1'b0;
  logic pend_ls = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .MAX_LS_STREAK(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic is_ls, input logic [31:0] data);
    exp_t e;
    e.is_ls = is_ls;
    e.data  = data;
    sb.push_back(e);
  endtask

  // Scoreboard pop and protocol invariants, sampled mid-cycle
  always @(negedge clk_i) begin
    chk("one_gnt", {63'd0, if_gnt_o & ls_gnt_o}, 64'd0);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rvalid_ls", {62'd0, ls_rvalid_o, if_rvalid_o}, {62'd0, e.is_ls, !e.is_ls});
      chk("rdata", {32'd0, (e.is_ls ? ls_rdata_o : if_rdata_o)}, {32'd0, e.data});
      chk("rdata_other_zero", {32'd0, (e.is_ls ? if_rdata_o : ls_rdata_o)}, 64'd0);
    end else begin
      chk("unexpected_rvalid", {62'd0, if_rvalid_o, ls_rvalid_o}, 64'd0);
    end
    if (rst_i) begin
      pend_if = 1'b0;
      pend_ls = 1'b0;
    end else begin
      if (if_gnt_o || ls_gnt_o)
        chk("gnt_while_pending", {63'd0, pend_if | pend_ls}, 64'd0);
      if (if_rvalid_o) begin
        chk("if_rvalid_paired", {63'd0, pend_if}, 64'd1);
        pend_if = 1'b0;
      end
      if (ls_rvalid_o) begin
        chk("ls_rvalid_paired", {63'd0, pend_ls}, 64'd1);
        pend_ls = 1'b0;
      end
      if (if_gnt_o) pend_if = 1'b1;
      if (ls_gnt_o) pend_ls = 1'b1;
    end
  end

  logic [2:0] exp_streak [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

  initial begin
    // Reset with requests present: handshake outputs stay silent
    if_req_i  = 1'b1;
    mem_gnt_i = 1'b1;
    tick();
    #2;
    chk("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    chk("rst_if_gnt", {63'd0, if_gnt_o}, 64'd0);
    tick();
    rst_i     = 1'b0;
    if_req_i  = 1'b0;
    mem_gnt_i = 1'b0;
    #2;
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_err", {63'd0, err_o}, 64'd0);
    chk("reset_streak", {61'd0, dut.streak_q}, 64'd0);
    chk("idle_mem_req", {63'd0, mem_req_o}, 64'd0);

    // IF-only read with immediate grant
    tick();
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    mem_gnt_i = 1'b1;
    #2;
    chk("t1_mem_req", {63'd0, mem_req_o}, 64'd1);
    chk("t1_addr", {32'd0, mem_addr_o}, 64'h100);
    chk("t1_we", {63'd0, mem_we_o}, 64'd0);
    chk("t1_be", {60'd0, mem_be_o}, 64'hF);
    chk("t1_if_gnt", {63'd0, if_gnt_o}, 64'd1);
    chk("t1_ls_gnt", {63'd0, ls_gnt_o}, 64'd0);
    tick();
    if_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEADBEEF;
    push(1'b0, 32'hDEADBEEF);
    #2;
    chk("t1_resp_mem_req", {63'd0, mem_req_o}, 64'd0);
    chk("t1_resp_busy", {63'd0, busy_o}, 64'd1);
    tick();
    mem_rvalid_i = 1'b0;
    #2;
    chk("t1_idle_busy", {63'd0, busy_o}, 64'd0);

    // Simultaneous requests: LS write wins, IF follows in the next IDLE cycle
    tick();
    if_req_i   = 1'b1;
    if_addr_i  = 32'h300;
    ls_req_i   = 1'b1;
    ls_we_i    = 1'b1;
    ls_be_i    = 4'b0011;
    ls_addr_i  = 32'h200;
    ls_wdata_i = 32'h12345678;
    mem_gnt_i  = 1'b1;
    #2;
    chk("t2_ls_gnt", {63'd0, ls_gnt_o}, 64'd1);
    chk("t2_if_gnt", {63'd0, if_gnt_o}, 64'd0);
    chk("t2_we", {63'd0, mem_we_o}, 64'd1);
    chk("t2_be", {60'd0, mem_be_o}, 64'h3);
    chk("t2_addr", {32'd0, mem_addr_o}, 64'h200);
    chk("t2_wdata", {32'd0, mem_wdata_o}, 64'h12345678);
    tick();
    ls_req_i     = 1'b0;
    ls_we_i      = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE0001;
    push(1'b1, 32'hCAFE0001);
    #2;
    chk("t2_streak_after_ls", {61'd0, dut.streak_q}, 64'd1);
    chk("t2_resp_if_gnt", {63'd0, if_gnt_o}, 64'd0);
    tick();
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b1;
    #2;
    chk("t2_if_gnt_next", {63'd0, if_gnt_o}, 64'd1);
    chk("t2_if_addr", {32'd0, mem_addr_o}, 64'h300);
    chk("t2_if_we", {63'd0, mem_we_o}, 64'd0);
    chk("t2_if_wdata", {32'd0, mem_wdata_o}, 64'd0);
    tick();
    if_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h00000033;
    push(1'b0, 32'h00000033);
    #2;
    chk("t2_streak_after_if", {61'd0, dut.streak_q}, 64'd0);
    tick();
    mem_rvalid_i = 1'b0;

    // Starvation guard: four LS grants, then IF, then LS again
    if_req_i  = 1'b1;
    if_addr_i = 32'h700;
    ls_req_i  = 1'b1;
    ls_addr_i = 32'h800;
    ls_be_i   = 4'hF;
    for (int k = 0; k < 6; k++) begin
      tick();
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b0;
      #2;
      chk($sformatf("t3_ls_gnt_%0d", k), {63'd0, ls_gnt_o}, {63'd0, k != 4});
      chk($sformatf("t3_if_gnt_%0d", k), {63'd0, if_gnt_o}, {63'd0, k == 4});
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hA000 + k;
      push(k != 4, 32'hA000 + k);
      #2;
      chk($sformatf("t3_streak_%0d", k), {61'd0, dut.streak_q}, {61'd0, exp_streak[k]});
    end
    tick();
    if_req_i     = 1'b0;
    ls_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;

    // Grant stall: IF decision locked while LS arrives
    tick();
    if_req_i  = 1'b1;
    if_addr_i = 32'h400;
    #2;
    chk("t4_mem_req", {63'd0, mem_req_o}, 64'd1);
    chk("t4_addr0", {32'd0, mem_addr_o}, 64'h400);
    chk("t4_if_gnt0", {63'd0, if_gnt_o}, 64'd0);
    tick();
    ls_req_i  = 1'b1;
    ls_addr_i = 32'h500;
    for (int s = 0; s < 2; s++) begin
      #2;
      chk($sformatf("t4_addr_stall_%0d", s), {32'd0, mem_addr_o}, 64'h400);
      chk($sformatf("t4_ls_gnt_stall_%0d", s), {63'd0, ls_gnt_o}, 64'd0);
      chk($sformatf("t4_if_gnt_stall_%0d", s), {63'd0, if_gnt_o}, 64'd0);
      chk($sformatf("t4_busy_stall_%0d", s), {63'd0, busy_o}, 64'd1);
      tick();
    end
    mem_gnt_i = 1'b1;
    #2;
    chk("t4_if_gnt", {63'd0, if_gnt_o}, 64'd1);
    chk("t4_ls_gnt", {63'd0, ls_gnt_o}, 64'd0);
    chk("t4_addr_gnt", {32'd0, mem_addr_o}, 64'h400);
    tick();
    if_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h44;
    push(1'b0, 32'h44);
    tick();
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b1;
    #2;
    chk("t4_ls_gnt_after", {63'd0, ls_gnt_o}, 64'd1);
    chk("t4_ls_addr", {32'd0, mem_addr_o}, 64'h500);
    tick();
    ls_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h55;
    push(1'b1, 32'h55);
    tick();
    mem_rvalid_i = 1'b0;

    // Spurious response in IDLE sets a sticky error
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h99;
    #2;
    chk("t5_err_before", {63'd0, err_o}, 64'd0);
    tick();
    mem_rvalid_i = 1'b0;
    #2;
    chk("t5_err_set", {63'd0, err_o}, 64'd1);
    tick();
    #2;
    chk("t5_err_sticky", {63'd0, err_o}, 64'd1);

    // Reset during RESP abandons the transaction; a late response is spurious
    tick();
    if_req_i  = 1'b1;
    if_addr_i = 32'h600;
    mem_gnt_i = 1'b1;
    #2;
    chk("t5_if_gnt", {63'd0, if_gnt_o}, 64'd1);
    tick();
    if_req_i  = 1'b0;
    mem_gnt_i = 1'b0;
    rst_i     = 1'b1;
    #2;
    chk("t5_rst_in_resp_busy", {63'd0, busy_o}, 64'd1);
    tick();
    rst_i        = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h66;
    #2;
    chk("t5_post_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("t5_post_rst_err", {63'd0, err_o}, 64'd0);
    chk("t5_post_rst_streak", {61'd0, dut.streak_q}, 64'd0);
    tick();
    mem_rvalid_i = 1'b0;
    #2;
    chk("t5_late_err", {63'd0, err_o}, 64'd1);
    tick();
    chk("sb_drained", {32'd0, 32'(sb.size())}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
